// File: rtl/prefix_state_tracker.sv
// Per-instruction prefix state for the 8086-compatible core: latches segment
// override, LOCK and REP prefixes, counts prefixes and resolves the segment select.
module prefix_state_tracker #(
  parameter int unsigned SR_WIDTH     = 2,
  parameter int unsigned SS_INDEX     = 2,
  parameter int unsigned MAX_PREFIXES = 4,
  parameter int unsigned CNT_WIDTH    = $clog2(MAX_PREFIXES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 next_instruction,
  input  logic                 force_segment,
  input  logic                 bp_is_base,
  input  logic                 segment_override,
  input  logic                 lock_prefix,
  input  logic                 rep_prefix,
  input  logic                 rep_z,
  input  logic [SR_WIDTH-1:0]  microcode_sr_rd_sel,
  output logic [SR_WIDTH-1:0]  sr_rd_sel,
  output logic                 override_active,
  output logic                 lock_active,
  output logic                 rep_active,
  output logic                 rep_is_z,
  output logic [CNT_WIDTH-1:0] prefix_count,
  output logic                 prefix_overflow
);

  // Two guard bits so count + up to three strobes can never wrap.
  localparam int unsigned SUM_W = CNT_WIDTH + 2;

  logic [SR_WIDTH-1:0] override;
  logic [SUM_W-1:0]    strobe_cnt;
  logic [SUM_W-1:0]    count_sum;
  logic                count_sat;

  always_comb begin
    strobe_cnt = SUM_W'(segment_override) + SUM_W'(lock_prefix) + SUM_W'(rep_prefix);
    count_sum  = SUM_W'(prefix_count) + strobe_cnt;
    count_sat  = count_sum > SUM_W'(MAX_PREFIXES);
  end

  // Segment select resolution; an override strobe this cycle bypasses the latch.
  always_comb begin
    sr_rd_sel = microcode_sr_rd_sel;
    if (force_segment || segment_override) begin
      sr_rd_sel = microcode_sr_rd_sel;
    end else if (override_active) begin
      sr_rd_sel = override;
    end else if (bp_is_base) begin
      sr_rd_sel = SR_WIDTH'(SS_INDEX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      override        <= '0;
      override_active <= 1'b0;
      lock_active     <= 1'b0;
      rep_active      <= 1'b0;
      rep_is_z        <= 1'b0;
      prefix_count    <= '0;
      prefix_overflow <= 1'b0;
    end else if (next_instruction) begin
      override        <= '0;
      override_active <= 1'b0;
      lock_active     <= 1'b0;
      rep_active      <= 1'b0;
      rep_is_z        <= 1'b0;
      prefix_count    <= '0;
      prefix_overflow <= 1'b0;
    end else begin
      if (segment_override) begin
        override        <= microcode_sr_rd_sel;
        override_active <= 1'b1;
      end
      if (lock_prefix) begin
        lock_active <= 1'b1;
      end
      if (rep_prefix) begin
        rep_active <= 1'b1;
        rep_is_z   <= rep_z;
      end
      if (count_sat) begin
        prefix_count    <= CNT_WIDTH'(MAX_PREFIXES);
        prefix_overflow <= 1'b1;
      end else begin
        prefix_count <= CNT_WIDTH'(count_sum);
      end
    end
  end

endmodule

// File: tb/tb_prefix_state_tracker.sv
// Scoreboard bench for prefix_state_tracker with default parameters.
module tb_prefix_state_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       next_instruction, force_segment, bp_is_base;
  logic       segment_override, lock_prefix, rep_prefix, rep_z;
  logic [1:0] microcode_sr_rd_sel;
  logic [1:0] sr_rd_sel;
  logic       override_active, lock_active, rep_active, rep_is_z;
  logic [2:0] prefix_count;
  logic       prefix_overflow;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       ova;
    logic       lk;
    logic       rp;
    logic       rz;
    logic [2:0] cnt;
    logic       of;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [1:0] m_ov;
  logic       m_ova, m_lk, m_rp, m_rz, m_of;
  int         m_cnt;

  prefix_state_tracker dut (
    .clk                 (clk),
    .reset               (reset),
    .next_instruction    (next_instruction),
    .force_segment       (force_segment),
    .bp_is_base          (bp_is_base),
    .segment_override    (segment_override),
    .lock_prefix         (lock_prefix),
    .rep_prefix          (rep_prefix),
    .rep_z               (rep_z),
    .microcode_sr_rd_sel (microcode_sr_rd_sel),
    .sr_rd_sel           (sr_rd_sel),
    .override_active     (override_active),
    .lock_active         (lock_active),
    .rep_active          (rep_active),
    .rep_is_z            (rep_is_z),
    .prefix_count        (prefix_count),
    .prefix_overflow     (prefix_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_ov = 2'd0; m_ova = 0; m_lk = 0; m_rp = 0; m_rz = 0; m_of = 0; m_cnt = 0;
  endtask

  // Drive one cycle, check the combinational select, then score the registered state.
  task automatic step(input logic ni, input logic fs, input logic bp, input logic so,
                      input logic lk, input logic rp, input logic rz, input logic [1:0] sel);
    logic [1:0] exp_sel;
    exp_t       e;
    int         n;
    @(negedge clk);
    next_instruction = ni; force_segment = fs; bp_is_base = bp; segment_override = so;
    lock_prefix = lk; rep_prefix = rp; rep_z = rz; microcode_sr_rd_sel = sel;
    #1;
    if (fs || so)     exp_sel = sel;
    else if (m_ova)   exp_sel = m_ov;
    else if (bp)      exp_sel = 2'd2;
    else              exp_sel = sel;
    check("sr_rd_sel", 32'(sr_rd_sel), 32'(exp_sel));
    if (ni) begin
      model_clear();
    end else begin
      if (so) begin m_ov = sel; m_ova = 1; end
      if (lk) m_lk = 1;
      if (rp) begin m_rp = 1; m_rz = rz; end
      n = int'(so) + int'(lk) + int'(rp);
      if (m_cnt + n > 4) begin m_cnt = 4; m_of = 1; end
      else m_cnt = m_cnt + n;
    end
    e = '{ova: m_ova, lk: m_lk, rp: m_rp, rz: m_rz, cnt: 3'(m_cnt), of: m_of};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("override_active", 32'(override_active), 32'(e.ova));
    check("lock_active",     32'(lock_active),     32'(e.lk));
    check("rep_active",      32'(rep_active),      32'(e.rp));
    check("rep_is_z",        32'(rep_is_z),        32'(e.rz));
    check("prefix_count",    32'(prefix_count),    32'(e.cnt));
    check("prefix_overflow", 32'(prefix_overflow), 32'(e.of));
  endtask

  task automatic idle(input logic bp, input logic [1:0] sel);
    step(0, 0, bp, 0, 0, 0, 0, sel);
  endtask

  initial begin
    reset = 1'b1;
    next_instruction = 0; force_segment = 0; bp_is_base = 1; segment_override = 0;
    lock_prefix = 0; rep_prefix = 0; rep_z = 0; microcode_sr_rd_sel = 2'd3;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_sel",   32'(sr_rd_sel), 32'd2);
    check("rst_flags", 32'({override_active, lock_active, rep_active, rep_is_z, prefix_overflow}), 32'd0);
    check("rst_count", 32'(prefix_count), 32'd0);

    // ES override, then BP addressing picks the latched ES; force wins over latch
    step(0, 0, 0, 1, 0, 0, 0, 2'd0);
    idle(1, 2'd3);
    check("es_sel", 32'(sr_rd_sel), 32'd0);
    check("es_cnt", 32'(prefix_count), 32'd1);
    step(0, 1, 1, 0, 0, 0, 0, 2'd3);
    step(1, 0, 1, 0, 0, 0, 0, 2'd3);

    // CS then DS: last override wins, then instruction boundary clears
    step(0, 0, 0, 1, 0, 0, 0, 2'd1);
    step(0, 0, 0, 1, 0, 0, 0, 2'd3);
    idle(1, 2'd0);
    check("ds_sel", 32'(sr_rd_sel), 32'd3);
    check("ds_cnt", 32'(prefix_count), 32'd2);
    step(1, 0, 1, 0, 0, 0, 0, 2'd0);
    check("ni_cnt", 32'(prefix_count), 32'd0);

    // Three prefixes in one cycle, then REP flips flavour to REPE
    step(0, 0, 0, 1, 1, 1, 0, 2'd1);
    check("tri_cnt", 32'(prefix_count), 32'd3);
    step(0, 0, 0, 0, 0, 1, 1, 2'd0);
    check("rep_z_cnt", 32'(rep_is_z), 32'd1);
    check("four_cnt",  32'(prefix_count), 32'd4);
    step(0, 0, 0, 1, 1, 1, 1, 2'd2);
    check("sat_multi", 32'({prefix_overflow, prefix_count}), 32'h0c);
    step(1, 0, 0, 0, 0, 0, 0, 2'd0);

    // Five LOCKs: count saturates at 4 and overflow sticks
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 0, 2'd0);
    check("lock5_cnt", 32'(prefix_count), 32'd4);
    check("lock5_ovf", 32'(prefix_overflow), 32'd1);
    for (int i = 0; i < 3; i++) idle(0, 2'd1);
    check("ovf_sticky", 32'(prefix_overflow), 32'd1);

    // Boundary beats a simultaneous override
    step(1, 0, 1, 1, 0, 0, 0, 2'd1);
    check("ni_so_ova", 32'(override_active), 32'd0);
    check("ni_so_cnt", 32'(prefix_count), 32'd0);

    // Async reset mid-instruction with two prefixes pending
    step(0, 0, 0, 1, 1, 0, 0, 2'd0);
    idle(1, 2'd3);
    check("pre_rst_cnt", 32'(prefix_count), 32'd2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_flags", 32'({override_active, lock_active, rep_active, rep_is_z, prefix_overflow}), 32'd0);
    check("async_cnt",   32'(prefix_count), 32'd0);
    check("async_sel",   32'(sr_rd_sel), 32'd2);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 1, 0, 2'd0);
    idle(1, 2'd1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prefix_state_tracker.md
Name: prefix_state_tracker

Overview:
- Per-instruction prefix state register for the 8086-compatible core.
- Tracks segment override, LOCK and REP/REPNE prefixes across prefix bytes, and counts the prefixes seen.
- Resolves the segment-register read select for the microcode datapath.
- Generalises single-override tracking to a parametrised segment index width, configurable stack-segment code, prefix counting with saturation, and LOCK/REP state. All state clears on instruction boundary.

Parameters:
- SR_WIDTH, 2, width of segment register select (2 = ES/CS/SS/DS).
- SS_INDEX, 2, select value used for BP-based addressing when no override is active.
- MAX_PREFIXES, 4, prefix count saturation point; must be >= 1.
- CNT_WIDTH, $clog2(MAX_PREFIXES+1), width of prefix_count (derived; do not override).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- next_instruction  in  1  instruction boundary strobe; clears all prefix state
- force_segment  in  1  microcode forces its own segment select
- bp_is_base  in  1  current effective address uses BP as base
- segment_override  in  1  segment override prefix strobe; segment in microcode_sr_rd_sel
- lock_prefix  in  1  LOCK prefix strobe
- rep_prefix  in  1  REP-family prefix strobe
- rep_z  in  1  with rep_prefix: 1 = REP/REPE, 0 = REPNE
- microcode_sr_rd_sel  in  SR_WIDTH  microcode segment select
- sr_rd_sel  out  SR_WIDTH  resolved segment select (combinational)
- override_active  out  1  a segment override is latched
- lock_active  out  1  LOCK latched
- rep_active  out  1  REP latched
- rep_is_z  out  1  latched REP flavour
- prefix_count  out  CNT_WIDTH  prefixes accepted this instruction, saturating
- prefix_overflow  out  1  sticky: more than MAX_PREFIXES prefixes seen

Behaviour:
- Reset (asynchronous): all registered outputs 0 (override, override_active, lock_active, rep_active, rep_is_z, prefix_count, prefix_overflow).
  - sr_rd_sel follows the combinational rule below.
- sr_rd_sel priority, first match wins, zero latency:
  1. force_segment or segment_override: microcode_sr_rd_sel.
  2. override_active: latched override.
  3. bp_is_base: SS_INDEX.
  4. Otherwise: microcode_sr_rd_sel.
- Register update on posedge clk, priority order:
  1. next_instruction: clear all state to reset values. Any prefix strobes in the same cycle are discarded.
  2. Otherwise, each asserted strobe updates its own state independently in the same cycle:
     - segment_override: override <= microcode_sr_rd_sel; override_active <= 1. Last override wins.
     - lock_prefix: lock_active <= 1. Repeated LOCK is idempotent for state but still counted.
     - rep_prefix: rep_active <= 1; rep_is_z <= rep_z. Last REP wins, so REPNE followed by REP gives rep_is_z = 1.
- Prefix count:
  - Let n = number of strobes asserted in the cycle (0..3).
  - If prefix_count + n > MAX_PREFIXES: prefix_count <= MAX_PREFIXES and prefix_overflow <= 1.
  - Otherwise: prefix_count <= prefix_count + n.
  - Compute the sum at CNT_WIDTH+2 bits so it cannot wrap.
- prefix_overflow is sticky until next_instruction or reset. Latched prefix state keeps updating after overflow; only the count saturates.
- Latched state persists indefinitely while no next_instruction arrives. This covers multi-cycle string loops.
- Reset asserted mid-instruction clears everything immediately; no pending state survives.
- No handshake: strobes are single-cycle qualifiers sampled on every edge. A strobe held high is counted on every cycle it is high.

Test Plan:
- Reset release, bp_is_base = 1, microcode_sr_rd_sel = 3 -> sr_rd_sel = 2 (SS_INDEX); all flags 0; prefix_count = 0.
- segment_override with sel = 0 (ES), then bp_is_base = 1, sel = 3 -> override_active = 1, sr_rd_sel = 0, prefix_count = 1. Then force_segment = 1 -> sr_rd_sel = 3.
- Overrides CS then DS on consecutive cycles -> sr_rd_sel = 3, prefix_count = 2. Then next_instruction -> sr_rd_sel = SS_INDEX under bp_is_base, count = 0.
- lock_prefix, rep_prefix (rep_z = 0) and segment_override (sel = 1) together in one cycle -> lock_active = 1, rep_active = 1, rep_is_z = 0, override_active = 1, prefix_count = 3. Next cycle rep_prefix with rep_z = 1 -> rep_is_z = 1, count = 4.
- MAX_PREFIXES = 4, five single lock strobes -> count 1,2,3,4,4; prefix_overflow = 1 after the 5th and stays 1 until next_instruction.
- next_instruction and segment_override in the same cycle -> override_active = 0, count = 0. Assert reset asynchronously mid-sequence with count = 2 -> all outputs 0 before the next edge.
